branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32 core.
- Looks up pc_IF combinationally in IF and supplies a predicted next PC to the PC unit.
- Trains from resolved branch/JAL outcomes in EX and flags mispredicts to the hazard unit.
- Supports bimodal or gshare indexing, a tagged BTB, and saturating performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BHT/BTB entries; power of two, 4..1024
TAG_BITS, 8, BTB tag width taken from PC above the index bits
MODE, 0, 0 = bimodal index, 1 = gshare (index XOR GHR)
GHR_BITS, 6, global history length; must be <= log2(ENTRIES); unused when MODE=0
CNT_BITS, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_if_i  in  XLEN  fetch PC
pred_taken_o  out  1  predicted taken for pc_if_i
pred_target_o  out  XLEN  predicted target; equals pc_if_i+4 when pred_taken_o=0
upd_valid_i  in  1  EX holds a valid resolved control-flow instruction
upd_pc_i  in  XLEN  PC of the resolved instruction
upd_is_branch_i  in  1  conditional branch
upd_is_jal_i  in  1  JAL (unconditional, fixed target)
upd_taken_i  in  1  actual outcome
upd_target_i  in  XLEN  actual target
upd_pred_taken_i  in  1  prediction carried down the pipeline with the instruction
upd_pred_target_i  in  XLEN  predicted target carried down the pipeline
mispredict_o  out  1  combinational redirect request
stat_branches_o  out  CNT_BITS  resolved branch+JAL count
stat_mispred_o  out  CNT_BITS  mispredict count

Behaviour:
- Index and tag:
  - IDXW = log2(ENTRIES).
  - idx = pc[IDXW+1:2]; in MODE=1, the low GHR_BITS of idx are XORed with the GHR.
  - tag = pc[IDXW+TAG_BITS+1 : IDXW+2].
  - The update path computes its index with the same function, using the current GHR.
- Per-entry state: 2-bit counter, valid, uncond flag, tag, target[XLEN-1:2].
- Lookup (0-cycle, combinational):
  - hit = valid && tag match.
  - pred_taken_o = hit && (uncond || cnt[1]).
  - pred_target_o = {target,2'b00} when taken, else pc_if_i+4 (wraps modulo 2^XLEN).
- Update (registered at the clk edge when upd_valid_i=1):
  - Branch: counter saturating increment if taken, decrement if not; saturates at 3 and 0.
  - Taken branch: writes tag, target, valid=1, uncond=0.
  - Not-taken branch: leaves tag, target and valid unchanged.
  - JAL: writes tag, target, valid=1, uncond=1; counter is not modified.
  - JALR and non-control instructions (both flags 0): no table write, no GHR shift, no stat count.
- GHR (MODE=1): on each resolved conditional branch, shifts left by one and inserts upd_taken_i at bit 0. It is non-speculative and is not affected by JAL.
- Mispredict:
  - mispredict_o = upd_valid_i && (upd_is_branch_i||upd_is_jal_i) && (upd_taken_i != upd_pred_taken_i || (upd_taken_i && upd_target_i != upd_pred_target_i)).
  - Purely combinational; the hazard unit flushes IF/ID and ID/EX on it.
- Simultaneous lookup and update of the same index: the lookup sees pre-update state, and the new state is visible on the next cycle.
- Tag alias on update: the entry is overwritten and the counter is not reset. A not-taken branch on a miss still trains the counter at its index.
- Stats: saturate at all-ones and do not wrap. stat_branches_o increments per counted update. stat_mispred_o increments when mispredict_o=1.
- Reset (asynchronous, any time including mid-update):
  - All counters = 2'b01 (weakly not-taken); all valid = 0; uncond = 0; GHR = 0; stats = 0.
  - Outputs during and after reset: pred_taken_o = 0, pred_target_o = pc_if_i+4, mispredict_o follows its inputs.
  - Tag and target arrays need not be reset.
- Upd_* inputs are don't-care when upd_valid_i=0.

Decomposition:
- Shared package `bp_pkg`:
  - `bp_mode_e` (BP_BIMODAL, BP_GSHARE).
  - 2-bit counter constants: SNT=0, WNT=1, WT=2, ST=3; reset value WNT.
  - Function `sat_cnt_next(cnt, taken)`.
- One natural sub-module `bp_sat_counter_array`:
  - ENTRIES×2-bit counter table with async read and a single write port.
  - Asynchronous reset to WNT.
  - Reused later by a return predictor.

Test Plan:
- Reset, then lookup pc=0x00000040 with upd_valid_i=0 -> pred_taken_o=0, pred_target_o=0x00000044, both stats 0.
- Branch at 0x100 resolved taken to 0x80 three times (pred_taken_i=0 each time):
  - Counter goes 1→2→3; mispredict_o=1 on all three, since pred_taken_i is held 0 by the bench.
  - Next lookup of 0x100 -> pred_taken_o=1, target 0x80.
  - stat_branches_o=3, stat_mispred_o=3.
- JAL at 0x200 to 0x1000 with pred_taken=0 -> mispredict_o=1. Next lookup of 0x200 -> taken, 0x1000. Then four not-taken branch updates at 0x200 -> still predicts taken (uncond flag survives). Then a taken branch update at 0x200 -> uncond cleared.
- Alias (ENTRIES=64, TAG_BITS=8): train 0x100 taken→0x80, then update 0x4100 taken→0x300 -> lookup 0x100 misses (pred_taken_o=0), lookup 0x4100 hits with target 0x300.
- MODE=1, GHR_BITS=2: pattern T,N,T,N at 0x300 repeated for 8 iterations -> mispredicts stop after warm-up; GHR alternates 01/10.
- Assert rst mid-update with upd_valid_i=1 -> no entry written; lookup of 0x100 after release -> not taken; stats=0. Drive 2^CNT_BITS+5 mispredicts with CNT_BITS=4 -> stat_mispred_o stays 0xF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types, counter encodings and helper for the branch predictor family.
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  // 2-bit saturating counter states
  localparam logic [1:0] SNT     = 2'd0;
  localparam logic [1:0] WNT     = 2'd1;
  localparam logic [1:0] WT      = 2'd2;
  localparam logic [1:0] ST      = 2'd3;
  localparam logic [1:0] CNT_RST = WNT;

  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (cnt == ST)  ? ST  : cnt + 2'd1;
    else       nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter_array.sv
// ENTRIES x 2-bit saturating counter table: two async read ports, one write port.
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  localparam int unsigned IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] rd_a_idx_i,
  output logic [1:0]      rd_a_cnt_o,
  input  logic [IDXW-1:0] rd_b_idx_i,
  output logic [1:0]      rd_b_cnt_o,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [1:0]      wr_cnt_i
);

  logic [1:0] r_cnt [ENTRIES];

  // Counter storage: reset to weakly not-taken, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '{default: CNT_RST};
    end else if (wr_en_i) begin
      r_cnt[wr_idx_i] <= wr_cnt_i;
    end
  end

  // Asynchronous reads
  always_comb begin
    rd_a_cnt_o = r_cnt[rd_a_idx_i];
    rd_b_cnt_o = r_cnt[rd_b_idx_i];
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: bimodal/gshare counters, tagged BTB, saturating stats.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned MODE     = 0,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_if_i,
  output logic                pred_taken_o,
  output logic [XLEN-1:0]     pred_target_o,
  input  logic                upd_valid_i,
  input  logic [XLEN-1:0]     upd_pc_i,
  input  logic                upd_is_branch_i,
  input  logic                upd_is_jal_i,
  input  logic                upd_taken_i,
  input  logic [XLEN-1:0]     upd_target_i,
  input  logic                upd_pred_taken_i,
  input  logic [XLEN-1:0]     upd_pred_target_i,
  output logic                mispredict_o,
  output logic [CNT_BITS-1:0] stat_branches_o,
  output logic [CNT_BITS-1:0] stat_mispred_o
);

  localparam int unsigned IDXW   = $clog2(ENTRIES);
  localparam int unsigned GW_RAW = (GHR_BITS > IDXW) ? IDXW : GHR_BITS;
  localparam int unsigned GW     = (GW_RAW == 0) ? 1 : GW_RAW;
  localparam bit          GSHARE = (MODE == int'(BP_GSHARE));

  logic [ENTRIES-1:0]  r_valid;
  logic [ENTRIES-1:0]  r_uncond;
  logic [TAG_BITS-1:0] r_tag [ENTRIES];
  logic [XLEN-3:0]     r_tgt [ENTRIES];
  logic [GW-1:0]       r_ghr;
  logic [CNT_BITS-1:0] r_stat_br;
  logic [CNT_BITS-1:0] r_stat_mp;

  logic [IDXW-1:0]     w_lk_idx;
  logic [IDXW-1:0]     w_up_idx;
  logic [1:0]          w_lk_cnt;
  logic [1:0]          w_up_cnt;
  logic                w_lk_hit;
  logic                w_is_br;
  logic                w_is_jal;
  logic                w_counted;
  logic                w_wr_entry;

  function automatic logic [IDXW-1:0] f_idx(input logic [XLEN-1:0] pc, input logic [GW-1:0] ghr);
    logic [IDXW-1:0] idx;
    idx = pc[IDXW+1:2];
    if (GSHARE) idx[GW-1:0] = idx[GW-1:0] ^ ghr;
    return idx;
  endfunction

  // Index, decode and write-enable generation for lookup and update paths
  always_comb begin
    w_lk_idx   = f_idx(pc_if_i, r_ghr);
    w_up_idx   = f_idx(upd_pc_i, r_ghr);
    // JAL takes precedence if both flags are ever set together
    w_is_jal   = upd_valid_i && upd_is_jal_i;
    w_is_br    = upd_valid_i && upd_is_branch_i && !upd_is_jal_i;
    w_counted  = w_is_jal || w_is_br;
    w_wr_entry = w_is_jal || (w_is_br && upd_taken_i);
  end

  bp_sat_counter_array #(.ENTRIES(ENTRIES)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .rd_a_idx_i (w_lk_idx),
    .rd_a_cnt_o (w_lk_cnt),
    .rd_b_idx_i (w_up_idx),
    .rd_b_cnt_o (w_up_cnt),
    .wr_en_i    (w_is_br),
    .wr_idx_i   (w_up_idx),
    .wr_cnt_i   (sat_cnt_next(w_up_cnt, upd_taken_i))
  );

  // Combinational lookup and mispredict detection
  always_comb begin
    w_lk_hit      = r_valid[w_lk_idx] &&
                    (r_tag[w_lk_idx] == pc_if_i[IDXW+TAG_BITS+1:IDXW+2]);
    pred_taken_o  = w_lk_hit && (r_uncond[w_lk_idx] || w_lk_cnt[1]);
    pred_target_o = pred_taken_o ? {r_tgt[w_lk_idx], 2'b00} : pc_if_i + XLEN'(4);
    mispredict_o  = upd_valid_i && (upd_is_branch_i || upd_is_jal_i) &&
                    ((upd_taken_i != upd_pred_taken_i) ||
                     (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    stat_branches_o = r_stat_br;
    stat_mispred_o  = r_stat_mp;
  end

  // Entry valid/uncond flags, global history and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_uncond  <= '0;
      r_ghr     <= '0;
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_wr_entry) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_uncond[w_up_idx] <= w_is_jal;
      end
      if (GSHARE && w_is_br) r_ghr <= GW'({r_ghr, upd_taken_i});
      if (w_counted && (r_stat_br != '1)) r_stat_br <= r_stat_br + 1'b1;
      if (mispredict_o && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 1'b1;
    end
  end

  // Tag/target storage; contents are qualified by r_valid so no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_entry) begin
      r_tag[w_up_idx] <= upd_pc_i[IDXW+TAG_BITS+1:IDXW+2];
      r_tgt[w_up_idx] <= upd_target_i[XLEN-1:2];
    end
  end

endmodule
